// File: rtl/store_buffer.sv
// Store buffer between the core store path and a single-port data memory.
// Stores queue in a circular FIFO, drain one per idle cycle, and forward to loads youngest-first.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [DW-1:0]            st_data,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_addr,
  output logic [DW-1:0]            ld_data,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wd,
  output logic                     mem_we,
  input  logic [DW-1:0]            mem_rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] entryAddr [DEPTH];
  logic [DW-1:0] entryData [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] fwdIdx;
  logic          push;
  logic          drain;

  assign empty    = (count == '0);
  assign st_ready = (count != CW'(DEPTH));
  assign push     = st_valid && st_ready;
  assign drain    = !empty && !ld_valid;

  assign mem_we   = drain;
  assign mem_addr = drain ? entryAddr[head] : ld_addr;
  assign mem_wd   = empty ? '0 : entryData[head];

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + 1'b1;
      if (drain)
        head <= head + 1'b1;
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; occupancy alone decides which slots are live.
  always_ff @(posedge Clk) begin
    if (push) begin
      entryAddr[tail] <= st_addr;
      entryData[tail] <= st_data;
    end
  end

  // Scan oldest to youngest so the last live match left standing is the youngest.
  always_comb begin
    ld_data = mem_rdata;
    fwdIdx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      fwdIdx = head + PW'(i);
      if ((CW'(i) < count) && (entryAddr[fwdIdx] == ld_addr))
        ld_data = entryData[fwdIdx];
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: vector table for forwarding, hand sequences for
// fill/drain/wrap/reset, and a write-order scoreboard fed from accepted stores.
module tb_store_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic                   Clk = 1'b0;
  logic                   Rst = 1'b0;
  logic                   st_valid = 1'b0;
  logic                   st_ready;
  logic [AW-1:0]          st_addr = '0;
  logic [DW-1:0]          st_data = '0;
  logic                   ld_valid = 1'b0;
  logic [AW-1:0]          ld_addr = '0;
  logic [DW-1:0]          ld_data;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wd;
  logic                   mem_we;
  logic [DW-1:0]          mem_rdata;
  logic [$clog2(DEPTH):0] count;
  logic                   empty;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .Clk(Clk), .Rst(Rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .count(count), .empty(empty)
  );

  // Memory model: unwritten words return a fixed pattern, word 16 holds 4.
  logic [DW-1:0] memArr [256];
  logic          memWritten [256] = '{default: 1'b0};

  function automatic logic [DW-1:0] defaultWord(input logic [7:0] a);
    return (a == 8'd16) ? 32'd4 : (32'hA000 + 32'(a));
  endfunction

  function automatic logic [DW-1:0] memWord(input logic [7:0] a);
    return memWritten[a] ? memArr[a] : defaultWord(a);
  endfunction

  assign mem_rdata = memWord(mem_addr[7:0]);

  always @(posedge Clk) begin
    if (mem_we) begin
      memArr[mem_addr[7:0]]     <= mem_wd;
      memWritten[mem_addr[7:0]] <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: accepted stores queue up, every memory write must match the oldest.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t expQ[$];
  wr_t sbHead;

  always @(negedge Clk) begin
    if (Rst) begin
      if (mem_we) begin
        if (expQ.size() == 0) begin
          checkOutput("sbUnexpectedWrite", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          sbHead = expQ.pop_front();
          checkOutput("sbWriteAddr", 64'(mem_addr), 64'(sbHead.addr));
          checkOutput("sbWriteData", 64'(mem_wd), 64'(sbHead.data));
        end
      end
      if (st_valid && st_ready)
        expQ.push_back({st_addr, st_data});
    end
  end

  task automatic applyStimulus(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                               input logic lv, input logic [AW-1:0] la);
    st_valid = sv;
    st_addr  = sa;
    st_data  = sd;
    ld_valid = lv;
    ld_addr  = la;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic drainAll(input string name);
    int n;
    n = 0;
    applyStimulus(1'b0, '0, '0, 1'b0, '0);
    while (!empty && n < 20) begin
      step();
      n++;
    end
    checkOutput(name, 64'(empty), 64'd1);
  endtask

  typedef struct {
    logic [AW-1:0] ldAddr;
    logic [DW-1:0] expData;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #100000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    vecs[0] = '{32'd12, 32'd9};
    vecs[1] = '{32'd16, 32'd4};
    vecs[2] = '{32'd20, 32'd55};
    vecs[3] = '{32'd13, 32'hA00D};
    vecs[4] = '{32'd21, 32'hA015};

    // Reset state
    #3;
    checkOutput("rstCount", 64'(count), 64'd0);
    checkOutput("rstEmpty", 64'(empty), 64'd1);
    checkOutput("rstReady", 64'(st_ready), 64'd1);
    checkOutput("rstMemWe", 64'(mem_we), 64'd0);
    #9 Rst = 1'b1;
    step();

    // Single store then idle drain
    applyStimulus(1'b1, 32'd8, 32'd20, 1'b0, 32'd0);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 32'd0);
    #1;
    checkOutput("oneWe", 64'(mem_we), 64'd1);
    checkOutput("oneAddr", 64'(mem_addr), 64'd8);
    checkOutput("oneWd", 64'(mem_wd), 64'd20);
    checkOutput("oneCount", 64'(count), 64'd1);
    step();
    checkOutput("oneWeAfter", 64'(mem_we), 64'd0);
    checkOutput("oneEmpty", 64'(empty), 64'd1);
    checkOutput("oneMem8", 64'(memWord(8'd8)), 64'd20);

    // Fill under a held load, stall the fifth store, then drain in order
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(40 + i), 32'(100 + i), 1'b1, 32'd200);
      step();
    end
    applyStimulus(1'b1, 32'd44, 32'd104, 1'b1, 32'd200);
    #1;
    checkOutput("fullCount", 64'(count), 64'd4);
    checkOutput("fullReady", 64'(st_ready), 64'd0);
    checkOutput("fullMemWe", 64'(mem_we), 64'd0);
    step();
    checkOutput("stallCount", 64'(count), 64'd4);
    applyStimulus(1'b0, '0, '0, 1'b0, 32'd0);
    #1;
    checkOutput("drainWe", 64'(mem_we), 64'd1);
    checkOutput("drainAddr0", 64'(mem_addr), 64'd40);
    for (int i = 0; i < 4; i++) begin
      step();
      checkOutput("drainCount", 64'(count), 64'(3 - i));
      if (i == 0)
        checkOutput("drainReady", 64'(st_ready), 64'd1);
      if (i < 3)
        checkOutput("drainAddrN", 64'(mem_addr), 64'(41 + i));
    end
    for (int i = 0; i < 4; i++)
      checkOutput("drainMem", 64'(memWord(8'(40 + i))), 64'(100 + i));

    // Forwarding table with loads holding the port
    applyStimulus(1'b1, 32'd12, 32'd7, 1'b1, 32'd12);
    step();
    applyStimulus(1'b1, 32'd12, 32'd9, 1'b1, 32'd12);
    step();
    applyStimulus(1'b1, 32'd20, 32'd55, 1'b1, 32'd12);
    step();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, '0, 1'b1, vecs[i].ldAddr);
      #1;
      checkOutput("fwdData", 64'(ld_data), 64'(vecs[i].expData));
      checkOutput("fwdMemWe", 64'(mem_we), 64'd0);
      checkOutput("fwdMemAddr", 64'(mem_addr), 64'(vecs[i].ldAddr));
      #1;
    end
    applyStimulus(1'b1, 32'd24, 32'd77, 1'b1, 32'd24);
    #1;
    checkOutput("sameCycleHidden", 64'(ld_data), 64'(defaultWord(8'd24)));
    step();
    applyStimulus(1'b0, '0, '0, 1'b1, 32'd24);
    #1;
    checkOutput("nextCycleFwd", 64'(ld_data), 64'd77);
    drainAll("fwdDrained");
    checkOutput("fwdMem12", 64'(memWord(8'd12)), 64'd9);
    checkOutput("fwdMem24", 64'(memWord(8'd24)), 64'd77);

    // Interleaved push/drain across pointer wrap
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 32'(60 + i), 32'(300 + i), 1'b0, 32'd0);
      step();
      checkOutput("wrapCount", 64'(count), 64'd1);
    end
    drainAll("wrapDrained");
    for (int i = 0; i < 6; i++)
      checkOutput("wrapMem", 64'(memWord(8'(60 + i))), 64'(300 + i));

    // Push and drain in the same cycle at count 2
    applyStimulus(1'b1, 32'd80, 32'd500, 1'b1, 32'd0);
    step();
    applyStimulus(1'b1, 32'd81, 32'd501, 1'b1, 32'd0);
    step();
    checkOutput("pdCountBefore", 64'(count), 64'd2);
    applyStimulus(1'b1, 32'd82, 32'd502, 1'b0, 32'd0);
    #1;
    checkOutput("pdWe", 64'(mem_we), 64'd1);
    checkOutput("pdAddrHead", 64'(mem_addr), 64'd80);
    step();
    applyStimulus(1'b0, '0, '0, 1'b0, 32'd0);
    #1;
    checkOutput("pdCountAfter", 64'(count), 64'd2);
    checkOutput("pdHeadAdv", 64'(mem_addr), 64'd81);
    step();
    checkOutput("pdTailAdv", 64'(mem_addr), 64'd82);
    drainAll("pdDrained");

    // Asynchronous reset in the middle of a drain with three entries left
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'(90 + i), 32'(600 + i), 1'b1, 32'd0);
      step();
    end
    applyStimulus(1'b0, '0, '0, 1'b0, 32'd0);
    step();
    checkOutput("midDrainCount", 64'(count), 64'd3);
    #2 Rst = 1'b0;
    #1;
    checkOutput("asyncCount", 64'(count), 64'd0);
    checkOutput("asyncEmpty", 64'(empty), 64'd1);
    checkOutput("asyncMemWe", 64'(mem_we), 64'd0);
    checkOutput("asyncReady", 64'(st_ready), 64'd1);
    expQ.delete();
    step();
    #3 Rst = 1'b1;
    step();
    checkOutput("rstMem90", 64'(memWord(8'd90)), 64'd600);
    checkOutput("rstMem91", 64'(memWord(8'd91)), 64'(defaultWord(8'd91)));
    applyStimulus(1'b1, 32'd100, 32'd700, 1'b0, 32'd0);
    step();
    drainAll("postRstDrained");
    checkOutput("postRstMem", 64'(memWord(8'd100)), 64'd700);

    checkOutput("sbQueueEmpty", 64'(expQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
